// File: rtl/wb_port_if.sv
// Writeback port bundle: two requester channels (A = ALU, B = load return)
// plus the registered register-file write port driven by the arbiter.
interface wb_port_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sel;

    // Pipeline side: drives requests, observes grants and the write port.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wr_en, wr_addr, wr_data, sel
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wr_en, wr_addr, wr_data, sel
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port shared by the
// ALU writeback (A) and load-return (B) paths. Grants are combinational; the
// winning write appears on the registered write port one cycle later.
// Writes to r0 are granted but discarded (wr_en stays low).
module wb_port_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    wb_port_if.slave         bus,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_A = 2'd1,
        WR_B = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              last_b;
    logic              a_grant;
    logic              b_grant;
    logic              both_valid;
    logic              sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    assign both_valid = bus.a_valid & bus.b_valid;

    // Grant: a lone requester wins; on contention the side that did not win
    // last time wins. Gated by rst_n so nothing is granted during reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (rst_n && !stall) begin
            if (both_valid) begin
                a_grant = last_b;
                b_grant = ~last_b;
            end else begin
                a_grant = bus.a_valid;
                b_grant = bus.b_valid;
            end
        end
    end

    assign bus.a_ready = a_grant;
    assign bus.b_ready = b_grant;

    // Next state: which requester's write will be on the port next cycle.
    always_comb begin
        state_d = IDLE;
        if (b_grant) begin
            state_d = WR_B;
        end else if (a_grant) begin
            state_d = WR_A;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winner's write; hold everything (including the round-robin
    // pointer) when nothing transfers. last_b resets to 1 so A wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            last_b <= 1'b1;
        end else if (b_grant) begin
            sel_q  <= 1'b1;
            addr_q <= bus.b_addr;
            data_q <= bus.b_data;
            last_b <= 1'b1;
        end else if (a_grant) begin
            sel_q  <= 1'b0;
            addr_q <= bus.a_addr;
            data_q <= bus.a_data;
            last_b <= 1'b0;
        end
    end

    // Saturating count of cycles in which both sides wanted the port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (both_valid && !stall && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    // Write enable comes purely from registers: a write is on the port and
    // its destination is not r0.
    assign bus.wr_en   = (state_q != IDLE) && (addr_q != '0);
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign bus.sel     = sel_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed and random requests checked against a
// behavioural model; expected write-port contents per cycle go through a
// scoreboard queue consumed by an independent monitor.
module tb_wb_port_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic [CNT_W-1:0] conflict_cnt;

    wb_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              sel;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: who won last, what sits on the write port, and
    // how many conflict cycles have been seen (clamped at the maximum).
    bit                m_last_b = 1'b1;
    logic              m_sel    = 1'b0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_data   = '0;
    int                m_cnt    = 0;

    // Requesters' pending writes (held until granted).
    bit                pa = 1'b0;
    bit                pb = 1'b0;
    logic [ADDR_W-1:0] pa_addr, pb_addr;
    logic [DATA_W-1:0] pa_data, pb_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each cycle, compare the write port with the scoreboard entry
    // scheduled for that cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q.pop_front();
            checks++;
            failures++;
            $display("FAIL sb_stale: entry for cycle %0d never compared", mon_e.cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            mon_e = sb_q.pop_front();
            check("wr_en",   64'(bus.wr_en),   64'(mon_e.en));
            check("wr_addr", 64'(bus.wr_addr), 64'(mon_e.addr));
            check("wr_data", 64'(bus.wr_data), 64'(mon_e.data));
            check("sel",     64'(bus.sel),     64'(mon_e.sel));
        end
    end

    // One cycle of stimulus: apply inputs away from the edge, check the
    // combinational grants, advance the model and schedule the expected
    // write-port contents for the next cycle.
    task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                         input logic st, output bit ga, output bit gb);
        exp_t e;
        @(negedge clk);
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
        bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
        bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
        stall = st;
        ga = 1'b0;
        gb = 1'b0;
        if (!st) begin
            if (av && bv) begin
                ga = m_last_b;
                gb = !m_last_b;
            end else begin
                ga = av;
                gb = bv;
            end
        end
        #1;
        check("a_ready", 64'(bus.a_ready), 64'(ga));
        check("b_ready", 64'(bus.b_ready), 64'(gb));
        if (av && bv && !st && m_cnt < CNT_MAX) m_cnt++;
        if (ga) begin
            m_sel = 1'b0; m_addr = aa; m_data = ad; m_last_b = 1'b0;
        end else if (gb) begin
            m_sel = 1'b1; m_addr = ba; m_data = bd; m_last_b = 1'b1;
        end
        e.cyc  = cyc + 1;
        e.en   = (ga || gb) && (m_addr != '0);
        e.addr = m_addr;
        e.data = m_data;
        e.sel  = m_sel;
        sb_q.push_back(e);
    endtask

    task automatic idle_cycle();
        bit ga, gb;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ga, gb);
    endtask

    // Random traffic: each idle requester raises a new write with probability
    // req_pct%, holds it until granted; stall asserted with probability stall_pct%.
    task automatic run_phase(input int n, input int req_pct, input int stall_pct);
        bit ga, gb, st;
        for (int i = 0; i < n; i++) begin
            if (!pa && ($urandom_range(99) < req_pct)) begin
                pa = 1'b1;
                pa_addr = ($urandom_range(7) == 0) ? '0 : ADDR_W'($urandom);
                pa_data = $urandom;
            end
            if (!pb && ($urandom_range(99) < req_pct)) begin
                pb = 1'b1;
                pb_addr = ($urandom_range(7) == 0) ? '0 : ADDR_W'($urandom);
                pb_data = $urandom;
            end
            st = ($urandom_range(99) < stall_pct);
            drive(pa, pa_addr, pa_data, pb, pb_addr, pb_data, st, ga, gb);
            if (ga) pa = 1'b0;
            if (gb) pb = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ga, gb;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        pa_addr = '0; pa_data = '0; pb_addr = '0; pb_data = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        #2;
        check("rst_wr_en",   64'(bus.wr_en),   64'd0);
        check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check("rst_sel",     64'(bus.sel),     64'd0);
        check("rst_cnt",     64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Contention for 6 cycles: A first, then alternating.
        run_phase(6, 100, 0);
        pa = 1'b0; pb = 1'b0;
        idle_cycle();
        check("cnt_after_contention", 64'(conflict_cnt), 64'd6);

        // Single requester A.
        drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, ga, gb);
        idle_cycle();
        check("single_a_wr_addr", 64'(bus.wr_addr), 64'd7);
        check("single_a_wr_data", 64'(bus.wr_data), 64'hDEAD_BEEF);

        // r0 discard from B.
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0, ga, gb);
        idle_cycle();

        // Stall with both valid, then release: A should win (B went last).
        run_phase(3, 100, 100);
        run_phase(2, 100, 0);
        pa = 1'b0; pb = 1'b0;
        idle_cycle();

        // Mixed random traffic.
        run_phase(400, 60, 20);
        pa = 1'b0; pb = 1'b0;
        idle_cycle();

        // Saturation: 300 consecutive conflict cycles.
        run_phase(300, 100, 0);
        check("cnt_saturated", 64'(conflict_cnt), 64'(CNT_MAX));
        run_phase(5, 100, 0);
        check("cnt_holds", 64'(conflict_cnt), 64'(CNT_MAX));

        // Asynchronous reset while a write is on the port.
        pa = 1'b0; pb = 1'b0;
        drive(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, '0, '0, 1'b0, ga, gb);
        @(posedge clk);
        #2;
        check("pre_rst_wr_en", 64'(bus.wr_en), 64'd1);
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en",   64'(bus.wr_en),    64'd0);
        check("midrst_sel",     64'(bus.sel),      64'd0);
        check("midrst_cnt",     64'(conflict_cnt), 64'd0);
        check("midrst_a_ready", 64'(bus.a_ready),  64'd0);
        check("midrst_b_ready", 64'(bus.b_ready),  64'd0);
        sb_q.delete();
        m_last_b = 1'b1; m_sel = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // After release, contention again starts with A.
        run_phase(4, 100, 0);
        pa = 1'b0; pb = 1'b0;
        idle_cycle();

        @(posedge clk);
        #2;
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
